// File: rtl/if_queue_pkg.sv
// Shared types for the fetch stage: machine word, instruction word and queue entry.
// idx_len gives the bit width needed to index n distinct values.
package if_queue_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] xlen_t;
    typedef logic [31:0]     inst_t;
    typedef logic            bool;

    localparam bool TRUE  = 1'b1;
    localparam bool FALSE = 1'b0;

    typedef struct packed {
        xlen_t pc;
        inst_t inst;
    } fq_entry_t;

    function automatic int idx_len(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prefix_count.sv
// Counts the leading ones of a bit vector starting at bit 0; the first zero ends the run.
module prefix_count
    import if_queue_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]                bits,
    output logic [idx_len(WIDTH+1)-1:0]     count
);

    localparam int CW = idx_len(WIDTH + 1);

    always_comb begin
        bool run;
        count = '0;
        run   = TRUE;
        for (int i = 0; i < WIDTH; i++) begin
            run = run & bits[i];
            if (run) count = count + CW'(1);
        end
    end

endmodule

// File: rtl/if_queue.sv
// Fetch stage: owns the fetch PC, accepts the contiguous hit prefix from the cache
// and buffers {pc, inst} pairs in a circular queue that decode pops from.
module if_queue
    import if_queue_pkg::*;
#(
    parameter int    WIDTH    = 2,
    parameter int    DEPTH    = 8,
    parameter xlen_t RESET_PC = 32'h0000_0000
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic                          fetch_req,
    output xlen_t                         fetch_pc,
    input  logic [WIDTH-1:0]              fetch_valid,
    input  logic [WIDTH*32-1:0]           fetch_data,
    input  logic                          redirect_valid,
    input  xlen_t                         redirect_pc,
    output logic [WIDTH-1:0]              dq_valid,
    output logic [WIDTH*XLEN-1:0]         dq_pc,
    output logic [WIDTH*32-1:0]           dq_inst,
    input  logic [idx_len(WIDTH+1)-1:0]   dq_pop
);

    localparam int NW = idx_len(WIDTH + 1);
    localparam int PW = idx_len(DEPTH);
    localparam int CW = idx_len(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;

    xlen_t           pc;
    ptr_t            head;
    ptr_t            tail;
    logic [CW-1:0]   count;
    fq_entry_t       entries [DEPTH];

    logic [CW-1:0]   free;
    logic [NW-1:0]   lead;
    logic [NW-1:0]   accept;
    logic            unused_pc_bits;

    prefix_count #(.WIDTH(WIDTH)) u_lead (
        .bits  (fetch_valid),
        .count (lead)
    );

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign fetch_pc       = pc;

    // Free space ignores same-cycle pops so the accept path never waits on decode.
    assign free      = CW'(DEPTH) - count;
    assign fetch_req = !redirect_valid && (free != '0);

    always_comb begin
        accept = '0;
        if (fetch_req) accept = (CW'(lead) > free) ? NW'(free) : lead;
    end

    always_comb begin
        dq_valid = '0;
        dq_pc    = '0;
        dq_inst  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dq_valid[i]              = CW'(i) < count;
            dq_pc[i*XLEN +: XLEN]    = entries[head + PW'(i)].pc;
            dq_inst[i*32 +: 32]      = entries[head + PW'(i)].inst;
        end
    end

    // Storage carries no reset; only entries below count are ever observed as valid.
    always_ff @(posedge clock) begin
        if (!reset && !redirect_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (NW'(i) < accept)
                    entries[tail + PW'(i)] <= '{pc: pc + XLEN'(4 * i), inst: fetch_data[i*32 +: 32]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            pc    <= pc + (XLEN'(accept) << 2);
            tail  <= tail + PW'(accept);
            head  <= head + PW'(dq_pop);
            count <= count + CW'(accept) - CW'(dq_pop);
        end
    end

endmodule

// File: doc/if_queue.md
Name: if_queue

Overview:
- Fetch stage with instruction queue, directly upstream of decode and the consumer of the banked instruction cache's per-lane fetch response.
- Owns the fetch PC and presents it to the cache each cycle.
- Accepts the contiguous valid prefix of returned instructions and buffers {pc, inst} pairs in a circular queue for decode.
- Handles redirects (branch/exception) by flushing the queue and reloading the PC.

Parameters:
- WIDTH, 2, fetch lanes per cycle; also the maximum decode pops per cycle.
- DEPTH, 8, queue entries; power of two, DEPTH >= 2*WIDTH.
- RESET_PC, 32'h0000_0000, PC loaded on reset; 4-byte aligned.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- fetch_req  out  1  request valid to the cache; high when free slots >= 1 and no redirect this cycle.
- fetch_pc  out  XLEN  PC of lane 0; lane i is fetch_pc+4*i.
- fetch_valid  in  WIDTH  per-lane hit from the cache.
- fetch_data  in  WIDTH*32  per-lane instruction words.
- redirect_valid  in  1  flush and restart.
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored and forced to 0.
- dq_valid  out  WIDTH  lane i holds the queue entry at head+i.
- dq_pc  out  WIDTH*XLEN  PC of each head entry.
- dq_inst  out  WIDTH*32  instruction of each head entry.
- dq_pop  in  IDX_LEN(WIDTH+1)  number of entries decode consumes this cycle.

Behaviour:
- State: pc register, head/tail pointers (IDX_LEN(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH), entry array.
- Reset: pc=RESET_PC, head=tail=count=0, dq_valid=0, fetch_req=1, fetch_pc=RESET_PC.
- Outputs: fetch_pc is a direct register output. dq_* are combinational from the head entries; dq_valid[i] = (i < count).
- free = DEPTH - count, computed from the current count only; same-cycle pops do not add space. This keeps the accept path off the decode path.
- Per-lane returned data is present the same cycle fetch_pc is driven, as a combinational cache answer.
- Accept count n:
  - n = number of leading ones in fetch_valid, i.e. the first 0 stops acceptance even if later lanes are valid.
  - n is capped at free.
  - n = 0 when fetch_req is low.
- Push: entry[tail+i] = {fetch_pc+4*i, fetch_data[i]} for i < n; tail += n.
- Pop: head += dq_pop.
  - dq_pop > count is illegal; bench assertion, RTL behaviour undefined.
- Counters: count_next = count + n - dq_pop. pc_next = pc + 4*n. PC arithmetic is XLEN wide and wraps silently at 2^XLEN.
- Miss (fetch_valid[0]=0): n=0, pc holds, fetch_req stays high, so the request repeats every cycle until hit.
- Full (count=DEPTH): fetch_req=0, n=0, pc holds; the queue still pops normally.
- Redirect (highest priority over push and pop):
  - Same cycle: fetch_req=0.
  - Next cycle: pc={redirect_pc[XLEN-1:2],2'b0}, head=tail=count=0; no push, dq_pop ignored.
  - dq_valid remains driven from the pre-flush state during the redirect cycle; decode must ignore it.
- Back-to-back redirects: the last one wins; each resets the queue.
- Reset mid-operation overrides redirect and everything else.
- Latency: an instruction returned in cycle t appears on dq_* in cycle t+1 at the earliest.

Decomposition:
- Shared package (defs.svh): XLEN, xlen_t, inst_t (32 bits), IDX_LEN macro, bool/TRUE/FALSE, and a new fq_entry_t {xlen_t pc; inst_t inst;}.
- One natural sub-module: prefix_count, a leading-ones counter of WIDTH bits with IDX_LEN(WIDTH+1) output, reusable by decode/rename.
- The queue storage and pointers stay inline.

Test Plan:
- Reset, then fetch_valid=2'b11 with data A,B and dq_pop=0 -> cycle 1: dq_valid=2'b11, dq_pc={0x0,0x4}, count=2, fetch_pc=0x8.
- fetch_valid=2'b10 at pc=0x8 -> n=0, fetch_pc stays 0x8 and fetch_req stays 1 for three miss cycles; then 2'b01 -> only the entry at 0x8 is pushed, fetch_pc=0xC.
- Continuous hits with dq_pop=0 -> count reaches 8 after 4 cycles; fetch_req=0 and fetch_pc frozen at 0x20. Then dq_pop=2 -> next cycle count=6; the following cycle pushes 2 and count=8 again.
- Steady state with count=4, push 2 and dq_pop=2 each cycle -> count stays 4; PCs on dq_pc strictly increase by 4 across wrap of head/tail past index 7.
- With count=5, redirect_valid=1 and redirect_pc=0x1003, fetch hit and dq_pop=2 in the same cycle -> next cycle count=0, dq_valid=0, fetch_pc=0x1000, no push recorded.
- Assert reset while count=6 and pc=0x40 -> next cycle count=0 and fetch_pc=RESET_PC; the redirect asserted in the same cycle is ignored.
